gray_sweep_ctrl: RTL and testbench

- Sequencer for the binary-to-gray converter datapath.
- On a start request it walks a binary value through a programmable range [lo, hi], up or down, and holds each code for a programmable number of cycles.
- It presents the binary value and the matching gray code on registered outputs, with a per-code valid strobe.
- Used to drive converter sweeps in hardware instead of from a bench loop; supports one-shot or continuous looping.

---
 rtl/gray_sweep_ctrl_pkg.sv | 28 ++
 rtl/gray_sweep_ctrl_bin2gray_conv.sv | 19 +
 rtl/gray_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gray_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_sweep_ctrl_pkg.sv
// ============================================================================
// Module  : gray_sweep_ctrl_pkg
// Brief   : Shared FSM encodings, direction constants and a popcount helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package gray_sweep_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sweep_ctrl_bin2gray_conv.sv
// ============================================================================
// Module  : bin2gray_conv
// Brief   : Combinational binary-to-gray converter, gray = bin ^ (bin >> 1).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2gray_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

`default_nettype wire

// File: rtl/gray_sweep_ctrl.sv
// ============================================================================
// Module  : gray_sweep_ctrl
// Brief   : Sweeps a binary value over [lo, hi] up or down, holding each code
//           hold+1 cycles, and presents binary + gray on registered outputs.
//           Optional gray-step self-check enabled by macro GRAY_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_sweep_ctrl
  import gray_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic              loop,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [HOLD_W-1:0] hold,
  output logic              busy,
  output logic              done,
  output logic              code_valid,
  output logic [WIDTH-1:0]  bin_out,
  output logic [WIDTH-1:0]  gray_out,
  output logic              err
);

  logic [1:0]        r_state;
  logic              r_dir;
  logic              r_loop;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_cv;
  logic [WIDTH-1:0]  r_bin;
  logic [WIDTH-1:0]  r_gray;

  logic              w_go;
  logic              w_empty;
  logic              w_step;
  logic              w_restart;
  logic [WIDTH-1:0]  w_end;
  logic [WIDTH-1:0]  w_first;
  logic [WIDTH-1:0]  w_bin_nxt;
  logic [WIDTH-1:0]  w_gray_nxt;

  assign w_go    = (r_state == ST_IDLE) && start && !stop;
  assign w_empty = (lo > hi);
  assign w_end   = (r_dir == DIR_DN) ? r_lo : r_hi;
  assign w_first = (r_dir == DIR_DN) ? r_hi : r_lo;

  // End-bound compare gates the step, so the full range never wraps.
  always_comb begin
    w_bin_nxt = r_bin;
    w_step    = 1'b0;
    w_restart = 1'b0;
    if (w_go && !w_empty) begin
      w_bin_nxt = (dir == DIR_DN) ? hi : lo;
    end else if ((r_state == ST_RUN) && !stop && (r_cnt == '0)) begin
      if (r_bin != w_end) begin
        w_step    = 1'b1;
        w_bin_nxt = (r_dir == DIR_DN) ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));
      end else if (r_loop) begin
        w_restart = 1'b1;
        w_bin_nxt = w_first;
      end
    end
  end

  bin2gray_conv #(.WIDTH(WIDTH)) u_conv (
    .i_bin  (w_bin_nxt),
    .o_gray (w_gray_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_loop  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cv    <= 1'b0;
      r_bin   <= '0;
      r_gray  <= '0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_cv   <= 1'b0;
          if (w_go) begin
            r_dir  <= dir;
            r_loop <= loop;
            r_lo   <= lo;
            r_hi   <= hi;
            r_hold <= hold;
            if (w_empty) begin
              r_state <= ST_FIN;
            end else begin
              r_cv    <= 1'b1;
              r_busy  <= 1'b1;
              r_cnt   <= hold;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_cv <= 1'b0;
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= ST_FIN;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end else if (w_step || w_restart) begin
            r_cv  <= 1'b1;
            r_cnt <= r_hold;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_cv    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_cv    <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign code_valid = r_cv;
  assign bin_out    = r_bin;
  assign gray_out   = r_gray;

`ifdef GRAY_CHECK_EN
  logic r_err;
  logic w_full;
  logic w_bad_hd;

  // Loop restarts on a partial range jump arbitrarily and are exempt.
  assign w_full   = (r_lo == '0) && (r_hi == '1);
  assign w_bad_hd = (popcount32(32'(w_gray_nxt ^ r_gray)) != 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_go) begin
      r_err <= 1'b0;
    end else if ((w_step || (w_restart && w_full)) && w_bad_hd) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_sweep_ctrl.sv
// ============================================================================
// Module  : tb_gray_sweep_ctrl
// Brief   : Directed bench for gray_sweep_ctrl with a cycle-trace model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gray_sweep_ctrl;

  localparam int W = 4;
  localparam int H = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         stop  = 1'b0;
  logic         dir   = 1'b0;
  logic         loop  = 1'b0;
  logic [W-1:0] lo    = '0;
  logic [W-1:0] hi    = '0;
  logic [H-1:0] hold  = '0;
  logic         busy, done, code_valid, err;
  logic [W-1:0] bin_out, gray_out;

  gray_sweep_ctrl #(.WIDTH(W), .HOLD_W(H)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .loop(loop),
    .lo(lo), .hi(hi), .hold(hold), .busy(busy), .done(done),
    .code_valid(code_valid), .bin_out(bin_out), .gray_out(gray_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         busy;
    logic         done;
    logic         cv;
    logic [W-1:0] bin;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] last_bin = '0;
  int           n_vec = 0;
  int           n_err = 0;
  int           cv_cnt = 0, busy_cnt = 0, done_cnt = 0;
  logic [W-1:0] glog[$];

  function automatic logic [W-1:0] gray_of(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the queued trace; idle when the trace is empty.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        last_bin = e.bin;
      end else begin
        e = '{1'b0, 1'b0, 1'b0, last_bin};
      end
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("code_valid", 32'(code_valid), 32'(e.cv));
      chk("bin_out", 32'(bin_out), 32'(e.bin));
      chk("gray_out", 32'(gray_out), 32'(gray_of(e.bin)));
      chk("err", 32'(err), 32'd0);
      if (code_valid === 1'b1) begin
        cv_cnt++;
        glog.push_back(gray_out);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  // Expand a sweep into its cycle-by-cycle expected outputs.
  task automatic plan(input logic d, input logic lp, input logic [W-1:0] lo_v,
                      input logic [W-1:0] hi_v, input logic [H-1:0] hold_v,
                      input int total, output int e_cnt);
    int n, tot, idx;
    logic [W-1:0] b;
    e_cnt = 0;
    if (lo_v > hi_v) begin
      q.push_back('{1'b0, 1'b0, 1'b0, last_bin});
      q.push_back('{1'b0, 1'b1, 1'b0, last_bin});
    end else begin
      n   = int'(hi_v) - int'(lo_v) + 1;
      tot = lp ? total : n;
      b   = last_bin;
      for (int i = 0; i < tot; i++) begin
        idx = i % n;
        b = d ? (hi_v - W'(idx)) : (lo_v + W'(idx));
        for (int h = 0; h <= int'(hold_v); h++) begin
          q.push_back('{1'b1, 1'b0, (h == 0), b});
        end
      end
      e_cnt = tot * (int'(hold_v) + 1);
      q.push_back('{1'b0, 1'b0, 1'b0, b});
      q.push_back('{1'b0, 1'b1, 1'b0, b});
    end
  endtask

  task automatic sweep(input logic d, input logic lp, input logic [W-1:0] lo_v,
                       input logic [W-1:0] hi_v, input logic [H-1:0] hold_v,
                       input int stop_after, input bit poke);
    int e_cnt;
    @(negedge clk);
    cv_cnt = 0; busy_cnt = 0; done_cnt = 0; glog.delete();
    start = 1'b1; dir = d; loop = lp; lo = lo_v; hi = hi_v; hold = hold_v;
    plan(d, lp, lo_v, hi_v, hold_v, stop_after, e_cnt);
    @(negedge clk);
    start = 1'b0; dir = ~d; loop = ~lp; lo = ~lo_v; hi = ~hi_v; hold = ~hold_v;
    for (int i = 1; i < e_cnt; i++) begin
      if (poke && i == 2) begin
        start = 1'b1; lo = '0; hi = '1; dir = 1'b0; hold = '0;
      end
      if (poke && i == 3) start = 1'b0;
      @(negedge clk);
    end
    if (stop_after > 0) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] g1 [16];
    logic [W-1:0] g2 [4];
    int           e_cnt;
    g1 = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    g2 = '{4'd5, 4'd7, 4'd6, 4'd2};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_gray", 32'(gray_out), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full range up, one shot.
    sweep(1'b0, 1'b0, 4'd0, 4'd15, 8'd0, 0, 1'b0);
    chk("t1_cv_cnt", 32'(cv_cnt), 32'd16);
    chk("t1_busy_cnt", 32'(busy_cnt), 32'd16);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_glog_len", 32'(glog.size()), 32'd16);
    for (int i = 0; i < 16 && i < glog.size(); i++) chk("t1_gray_seq", 32'(glog[i]), 32'(g1[i]));

    // Down with hold=2, start poked while busy.
    sweep(1'b1, 1'b0, 4'd3, 4'd6, 8'd2, 0, 1'b1);
    chk("t2_cv_cnt", 32'(cv_cnt), 32'd4);
    chk("t2_busy_cnt", 32'(busy_cnt), 32'd12);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_glog_len", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("t2_gray_seq", 32'(glog[i]), 32'(g2[i]));

    // Empty range.
    sweep(1'b0, 1'b0, 4'd9, 4'd4, 8'd0, 0, 1'b0);
    chk("t3_cv_cnt", 32'(cv_cnt), 32'd0);
    chk("t3_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_bin_hold", 32'(bin_out), 32'd3);

    // Loop 14/15, stop while showing 15.
    sweep(1'b0, 1'b1, 4'd14, 4'd15, 8'd0, 4, 1'b0);
    chk("t4_cv_cnt", 32'(cv_cnt), 32'd4);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_bin_hold", 32'(bin_out), 32'd15);

    // start together with stop is ignored.
    @(negedge clk);
    cv_cnt = 0; busy_cnt = 0; done_cnt = 0;
    start = 1'b1; stop = 1'b1; lo = 4'd1; hi = 4'd2; dir = 1'b0; loop = 1'b0; hold = '0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_cv_cnt", 32'(cv_cnt), 32'd0);
    chk("t5_done_cnt", 32'(done_cnt), 32'd0);
    chk("t5_bin_hold", 32'(bin_out), 32'd15);

    // Reset in the middle of a sweep while bin_out=7.
    @(negedge clk);
    cv_cnt = 0; busy_cnt = 0; done_cnt = 0;
    start = 1'b1; dir = 1'b0; loop = 1'b0; lo = 4'd0; hi = 4'd15; hold = '0;
    plan(1'b0, 1'b0, 4'd0, 4'd15, 8'd0, 0, e_cnt);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("t6_pre_bin", 32'(bin_out), 32'd7);
    rst = 1'b1;
    q.delete();
    last_bin = '0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cv", 32'(code_valid), 32'd0);
    chk("t6_bin", 32'(bin_out), 32'd0);
    chk("t6_gray", 32'(gray_out), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    sweep(1'b0, 1'b0, 4'd2, 4'd4, 8'd1, 0, 1'b0);
    chk("t6_after_cv", 32'(cv_cnt), 32'd3);
    chk("t6_after_done", 32'(done_cnt), 32'd1);

    // Full range loop, two passes.
    sweep(1'b0, 1'b1, 4'd0, 4'd15, 8'd0, 32, 1'b0);
    chk("t7_cv_cnt", 32'(cv_cnt), 32'd32);
    chk("t7_err", 32'(err), 32'd0);
    chk("t7_bin_hold", 32'(bin_out), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
